// File: rtl/mv_pkg.sv
// Shared definitions for the matrix-vector path: word width and sequencer states.
package mv_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } seq_state_e;

endpackage

// File: rtl/row_dot_sequencer_if.sv
// Chunk input, adder-tree/accumulator side and row-sum output of the row sequencer.
interface row_dot_sequencer_if #(
    parameter int unsigned NI = 8
);
    import mv_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [NI*WORD_W-1:0]   in_data;
    logic [NI*WORD_W-1:0]   dp_data;
    logic                   dp_valid;
    logic                   dp_acc_clr;
    logic [WORD_W-1:0]      dp_sum;
    logic                   out_valid;
    logic                   out_ready;
    logic [WORD_W-1:0]      out_data;

    modport slave (
        input  in_valid, in_data, dp_sum, out_ready,
        output in_ready, dp_data, dp_valid, dp_acc_clr, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, dp_sum, out_ready,
        input  in_ready, dp_data, dp_valid, dp_acc_clr, out_valid, out_data
    );

endinterface

// File: rtl/tag_delay_line.sv
// One-bit shift register of DEPTH stages with synchronous clear.
module tag_delay_line #(
    parameter int unsigned DEPTH = 9
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sr;

    if (DEPTH == 0) begin : g_bad_depth
        $error("tag_delay_line: DEPTH must be at least 1");
    end

    if (DEPTH == 1) begin : g_one
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)   sr <= '0;
            else if (clr) sr <= '0;
            else          sr <= d;
        end
    end else begin : g_many
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)   sr <= '0;
            else if (clr) sr <= '0;
            else          sr <= {sr[DEPTH-2:0], d};
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/row_dot_sequencer.sv
// Feeds one row through the adder tree chunk by chunk, then captures and returns the row sum.
module row_dot_sequencer
    import mv_pkg::*;
#(
    parameter int unsigned NI       = 8,
    parameter int unsigned ROW_LEN  = 64,
    parameter int unsigned TREE_LAT = 9,
    parameter int unsigned ACC_LAT  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    row_dot_sequencer_if.slave  bus,
    output logic                busy,
    output logic [15:0]         rows_done
);

    localparam int unsigned CHUNKS  = ROW_LEN / NI;
    localparam int unsigned CNT_W   = $clog2(CHUNKS + 1);
    localparam int unsigned DRAIN_N = TREE_LAT + ACC_LAT;
    localparam int unsigned DRAIN_W = $clog2(DRAIN_N + 1);
    localparam int unsigned GAP_W   = (ACC_LAT > 1) ? $clog2(ACC_LAT) : 1;

    if ((ROW_LEN % NI) != 0 || ROW_LEN == 0 || ACC_LAT == 0 || TREE_LAT == 0) begin : g_bad_params
        $error("row_dot_sequencer: ROW_LEN must be a nonzero multiple of NI, ACC_LAT and TREE_LAT nonzero");
    end

    seq_state_e             state_q, state_d;
    logic [CNT_W-1:0]       chunk_q, chunk_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic [DRAIN_W-1:0]     drain_q, drain_d;
    logic                   ready, accept, capture, deliver;
    logic [NI*WORD_W-1:0]   dp_data_q;
    logic                   dp_valid_q, dp_first_q, acc_clr;
    logic [WORD_W-1:0]      out_data_q;
    logic [15:0]            rows_q;

    always_comb begin
        state_d = state_q;
        chunk_d = chunk_q;
        gap_d   = gap_q;
        drain_d = drain_q;
        ready   = 1'b0;
        accept  = 1'b0;
        capture = 1'b0;
        deliver = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    chunk_d = CNT_W'(1);
                    gap_d   = GAP_W'(ACC_LAT - 1);
                    drain_d = '0;
                    state_d = (CHUNKS == 1) ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                // gap_cnt keeps successive dp_valid pulses ACC_LAT apart
                if (gap_q != '0) begin
                    gap_d = gap_q - 1'b1;
                end else begin
                    ready = 1'b1;
                    if (bus.in_valid) begin
                        accept  = 1'b1;
                        chunk_d = chunk_q + 1'b1;
                        gap_d   = GAP_W'(ACC_LAT - 1);
                        drain_d = '0;
                        if (chunk_q + 1'b1 == CNT_W'(CHUNKS)) state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_W'(DRAIN_N)) begin
                    capture = 1'b1;
                    state_d = OUT;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    deliver = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
            chunk_d = '0;
            gap_d   = '0;
            drain_d = '0;
            accept  = 1'b0;
            capture = 1'b0;
            deliver = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            chunk_q    <= '0;
            gap_q      <= '0;
            drain_q    <= '0;
            dp_data_q  <= '0;
            dp_valid_q <= 1'b0;
            dp_first_q <= 1'b0;
            out_data_q <= '0;
            rows_q     <= '0;
        end else begin
            state_q    <= state_d;
            chunk_q    <= chunk_d;
            gap_q      <= gap_d;
            drain_q    <= drain_d;
            dp_valid_q <= accept;
            dp_data_q  <= accept ? bus.in_data : '0;
            dp_first_q <= accept && (state_q == IDLE);
            if (flush)        out_data_q <= '0;
            else if (capture) out_data_q <= bus.dp_sum;
            if (deliver)      rows_q     <= rows_q + 1'b1;
        end
    end

    // The first chunk's tag reaches the end of the line just as its tree sum hits the accumulator
    tag_delay_line #(.DEPTH(TREE_LAT)) u_clr_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .d     (dp_first_q),
        .q     (acc_clr)
    );

    assign bus.in_ready   = ready;
    assign bus.dp_data    = dp_data_q;
    assign bus.dp_valid   = dp_valid_q;
    assign bus.dp_acc_clr = acc_clr;
    assign bus.out_valid  = (state_q == OUT);
    assign bus.out_data   = out_data_q;
    assign busy           = (state_q != IDLE);
    assign rows_done      = rows_q;

endmodule
